// File: rtl/huff_enc_sched.sv
// huff_enc_sched: round-robin job scheduler that loads, runs and collects one job at a time from a shared Huffman encoder
module huff_enc_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [23:0] req0_sym,
    input  logic [8:0]  req0_freq,
    input  logic [23:0] req1_sym,
    input  logic [8:0]  req1_freq,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [14:0] rsp_char,
    output logic [8:0]  rsp_mask,
    output logic [8:0]  rsp_code,
    output logic        rsp_err,
    output logic        enc_reset,
    output logic [11:0] enc_io_in,
    input  logic [11:0] enc_io_out,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FLUSH, LOAD, COLLECT, RESP} state_t;
    state_t state, state_nx;
    logic prio, winner, take, last_word, tmo;
    logic [23:0] sym;
    logic [8:0] freq;
    logic [1:0] k;
    logic [2:0] w;
    logic [TW-1:0] tcnt;
    logic unused_bits;
    assign unused_bits = ^{enc_io_out[11:9], enc_io_out[7:6]};
    always_comb begin
        winner = &req_valid ? prio : req_valid[1];
        take = state == IDLE && |req_valid;
        last_word = state == COLLECT && enc_io_out[8] && w == 3'd5;
        tmo = state == COLLECT && !last_word && tcnt == TW'(TIMEOUT - 1);
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req_valid ? FLUSH : IDLE;
            FLUSH:   state_nx = LOAD;
            LOAD:    state_nx = k == 2'd2 ? COLLECT : LOAD;
            COLLECT: state_nx = (last_word || tmo) ? RESP : COLLECT;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // Outputs derived from state are forced quiet while reset is held
    assign req_ready = (take && !reset) ? {winner, !winner} & req_valid : 2'b00;
    assign rsp_valid = state == RESP && !reset;
    assign busy = state != IDLE && !reset;
    assign enc_reset = reset || state == FLUSH || tmo;
    assign enc_io_in = (state == LOAD && !reset) ? {1'b1, freq[8:6], sym[23:16]} : 12'h000;
    // Captured request shifts left so the current slot always sits at the top
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio <= 1'b0;
            sym <= '0;
            freq <= '0;
            k <= '0;
            w <= '0;
            tcnt <= '0;
            rsp_id <= 1'b0;
            rsp_char <= '0;
            rsp_mask <= '0;
            rsp_code <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                prio <= !winner;
                rsp_id <= winner;
                sym <= winner ? req1_sym : req0_sym;
                freq <= winner ? req1_freq : req0_freq;
                k <= '0;
                w <= '0;
                tcnt <= '0;
                rsp_char <= '0;
                rsp_mask <= '0;
                rsp_code <= '0;
                rsp_err <= 1'b0;
            end
            if (state == LOAD) begin
                sym <= sym << 8;
                freq <= freq << 3;
                k <= k + 2'd1;
            end
            if (state == COLLECT) begin
                tcnt <= tcnt + 1'b1;
                if (enc_io_out[8]) begin
                    w <= w + 3'd1;
                    if (w[0]) begin
                        rsp_mask <= {rsp_mask[5:0], enc_io_out[5:3]};
                        rsp_code <= {rsp_code[5:0], enc_io_out[2:0]};
                    end else begin
                        rsp_char <= {rsp_char[9:0], enc_io_out[4:0]};
                    end
                end
                if (tmo) begin
                    rsp_char <= '0;
                    rsp_mask <= '0;
                    rsp_code <= '0;
                    rsp_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_huff_enc_sched.sv
// tb_huff_enc_sched: directed plus randomized jobs against a slot-level reference model and an encoder stub
module tb_huff_enc_sched;
    localparam int TO = 64;
    logic clk = 1'b0;
    logic reset;
    logic [1:0] req_valid, req_ready;
    logic [23:0] req0_sym, req1_sym;
    logic [8:0] req0_freq, req1_freq;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err, enc_reset, busy;
    logic [14:0] rsp_char;
    logic [8:0] rsp_mask, rsp_code;
    logic [11:0] enc_io_in, enc_io_out;
    int checks = 0, failures = 0;
    logic [8:0] words [8];
    int nwords = 6;
    bit gaps = 0;
    int loads = 0, emitted = 0;
    int pref = 0;

    always #5 clk = ~clk;

    huff_enc_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_sym(req0_sym), .req0_freq(req0_freq), .req1_sym(req1_sym), .req1_freq(req1_freq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_char(rsp_char),
        .rsp_mask(rsp_mask), .rsp_code(rsp_code), .rsp_err(rsp_err), .enc_reset(enc_reset),
        .enc_io_in(enc_io_in), .enc_io_out(enc_io_out), .busy(busy)
    );

    // Encoder stub: after three loads, emit the word list (optionally with random idle gaps)
    always @(posedge clk) begin
        if (enc_reset) begin
            loads <= 0;
            emitted <= 0;
            enc_io_out <= '0;
        end else begin
            if (enc_io_in[11]) loads <= loads + 1;
            if (loads >= 3 && emitted < nwords && (!gaps || $urandom_range(0, 1) == 1)) begin
                enc_io_out <= {3'b000, words[emitted[2:0]]};
                emitted <= emitted + 1;
            end else begin
                enc_io_out <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 = six words, 1 = encoder never done, 2 = eight words
    task automatic run_job(input logic [1:0] rv, input int mode, input bit gap, input bit directed, input int hold);
        logic [23:0] s;
        logic [8:0] f, em, ec;
        logic [14:0] ech;
        logic [11:0] eio;
        int id, n;
        bit seen;
        req0_sym = directed ? 24'h414243 : 24'($urandom);
        req0_freq = directed ? 9'o123 : 9'($urandom);
        req1_sym = 24'($urandom);
        req1_freq = 9'($urandom);
        words[0] = 9'h161; words[1] = 9'h105; words[2] = 9'h162;
        words[3] = 9'h11A; words[4] = 9'h163; words[5] = 9'h11B;
        for (int i = 0; i < 8; i++)
            if (!directed || i >= 6) words[i] = {1'b1, 8'($urandom)};
        nwords = mode == 1 ? 0 : (mode == 2 ? 8 : 6);
        gaps = gap;
        id = rv == 2'b11 ? pref : (rv[1] ? 1 : 0);
        pref = 1 - id;
        s = id == 1 ? req1_sym : req0_sym;
        f = id == 1 ? req1_freq : req0_freq;
        ech = '0; em = '0; ec = '0;
        if (mode != 1)
            for (int j = 0; j < 3; j++) begin
                ech[(2-j)*5 +: 5] = words[2*j][4:0];
                em[(2-j)*3 +: 3] = words[2*j+1][5:3];
                ec[(2-j)*3 +: 3] = words[2*j+1][2:0];
            end
        req_valid = rv;
        #1;
        chk("grant", req_ready, id == 1 ? 2'b10 : 2'b01);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("flush_enc_reset", enc_reset, 1);
        chk("flush_io", enc_io_in, 0);
        chk("flush_busy", busy, 1);
        chk("flush_ready", req_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            eio = {1'b1, f[(2-k)*3 +: 3], s[(2-k)*8 +: 8]};
            chk("load_io", enc_io_in, eio);
            chk("load_enc_reset", enc_reset, 0);
        end
        n = 4;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == TO + 4) chk("tmo_enc_reset", enc_reset, 1);
            seen = rsp_valid;
        end
        chk("rsp_seen", seen, 1);
        if (mode == 1) chk("tmo_latency", n, TO + 5);
        if (hold > 0) req_valid = 2'b10;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            #1;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, id);
            chk("rsp_char", rsp_char, ech);
            chk("rsp_mask", rsp_mask, em);
            chk("rsp_code", rsp_code, ec);
            chk("rsp_err", rsp_err, mode == 1);
            chk("resp_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_busy", busy, 0);
        if (hold > 0) chk("after_grant_ready", req_ready, 2'b10);
        req_valid = 2'b00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_sym = '0; req1_sym = '0; req0_freq = '0; req1_freq = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_enc_reset", enc_reset, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_io", enc_io_in, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_enc_reset", enc_reset, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_fields", {rsp_id, rsp_err, rsp_char, rsp_mask, rsp_code}, 0);
        chk("post_rst_io", enc_io_in, 0);
        pref = 0;
        run_job(2'b11, 0, 0, 1, 0);
        run_job(2'b11, 0, 0, 0, 0);
        run_job(2'b01, 2, 0, 1, 0);
        run_job(2'b10, 1, 0, 0, 0);
        run_job(2'b01, 0, 0, 1, 10);
        run_job(2'b11, 2, 1, 0, 2);
        for (int r = 0; r < 10; r++)
            run_job(2'($urandom_range(1, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3));
        req0_sym = 24'($urandom);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_enc_reset", enc_reset, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_io", enc_io_in, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        pref = 0;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("mid_rst_no_rsp", seen, 0);
        run_job(2'b11, 0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
